// File: rtl/muldiv_if.sv
// Operand/result bundle between the control unit and the multiply/divide unit.
//   start, op, a, b : request from the control unit (a = rs / RD1, b = rt / RD2)
//   busy, done      : status back to the control unit
//   hi, lo          : architectural HI/LO, feeding the MFHI/MFLO write-back mux
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the HI/LO registers.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset; aborts any operation in flight
//   bus  : slave side of muldiv_if
//            op 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//            busy high from accept until the FIX edge, done pulses for one
//            cycle once HI/LO hold the new result.
// Mul: radix-2 shift-add, LSB first. Div: restoring, MSB first. Both run on
// magnitudes for one iteration per operand bit, then fix up signs in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Mul: {partial product, multiplier}. Div: low half is dividend shifting
  // out MSB first while quotient bits shift in from the LSB.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder (div only)
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // |b|: multiplicand or divisor
  logic [WIDTH-1:0]   araw_q, araw_d;   // a as presented, for divide by zero
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               div_q, div_d;
  logic               sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic               done_q, done_d;

  logic               sgn_w;
  logic [WIDTH:0]     sum_w;            // mul add with carry out
  logic [WIDTH:0]     shl_w, trial_w;   // trial_w[WIDTH] is the borrow
  logic [2*WIDTH-1:0] prod_w;
  logic [WIDTH-1:0]   quo_w, rmd_w;

  assign sum_w   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign shl_w   = {rem_q, acc_q[WIDTH-1]};
  assign trial_w = shl_w - {1'b0, opnd_q};
  assign prod_w  = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo_w   = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rmd_w   = sa_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    opnd_d  = opnd_q;
    araw_d  = araw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    done_d  = 1'b0;
    sgn_w   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          unique case (bus.op)
            3'b100: hi_d = bus.a;
            3'b101: lo_d = bus.a;
            3'b000, 3'b001, 3'b010, 3'b011: begin
              sgn_w   = ~bus.op[0];
              sa_d    = sgn_w & bus.a[WIDTH-1];
              sb_d    = sgn_w & bus.b[WIDTH-1];
              acc_d   = {{WIDTH{1'b0}}, (sa_d ? -bus.a : bus.a)};
              opnd_d  = sb_d ? -bus.b : bus.b;
              rem_d   = '0;
              araw_d  = bus.a;
              bz_d    = (bus.b == '0);
              div_d   = bus.op[1];
              cnt_d   = '0;
              state_d = S_ITER;
            end
            default: ;  // reserved ops are dropped
          endcase
        end
      end
      S_ITER: begin
        if (!div_q) begin
          acc_d = acc_q[0] ? {sum_w, acc_q[WIDTH-1:1]}
                           : {1'b0, acc_q[2*WIDTH-1:1]};
        end else begin
          // Borrow set: keep the shifted remainder (restore), quotient bit 0.
          rem_d              = trial_w[WIDTH] ? shl_w[WIDTH-1:0] : trial_w[WIDTH-1:0];
          acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], ~trial_w[WIDTH]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!div_q) begin
          {hi_d, lo_d} = prod_w;
        end else if (bz_q) begin
          hi_d = araw_q;
          lo_d = '1;
        end else begin
          hi_d = rmd_w;
          lo_d = quo_w;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      opnd_q  <= '0;
      araw_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      opnd_q  <= opnd_d;
      araw_q  <= araw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat, bcnt;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Issue at the current point (between edges), accept on the next rising
  // edge, then count cycles until done. lat=1 is the first cycle after
  // accept; bcnt counts busy-high cycles. inj_cyc>0 drives an MTLO request
  // in that cycle while the unit should be busy.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int inj_cyc,
                        output int l, output int bc);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    l = 1; bc = 0;
    while (bus.done !== 1'b1 && l < 100) begin
      if (bus.busy === 1'b1) bc++;
      if (l == inj_cyc) begin
        bus.start = 1'b1; bus.op = OP_MTLO; bus.a = 32'h0000DEAD;
      end
      @(negedge clk);
      bus.start = 1'b0;
      l++;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want %h", bus.hi, 32'h0); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want %h", bus.lo, 32'h0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'h12345678; bus.b = 32'h0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++; if (bus.hi !== 32'h12345678) begin n_err++; $display("FAIL mthi_hi: got %h want %h", bus.hi, 32'h12345678); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL mthi_lo: got %h want %h", bus.lo, 32'h0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL mthi_done: got %b want 0", bus.done); end
  endtask

  task automatic test_mul();
    @(negedge clk);
    run_op(OP_MULT, 32'hFFFFFFFF, 32'h00000002, 0, lat, bcnt);
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL mult_latency: got %0d want 34", lat); end
    n_cmp++; if (bcnt !== 33) begin n_err++; $display("FAIL mult_busy_cycles: got %0d want 33", bcnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mult_busy_at_done: got %b want 0", bus.busy); end
    n_cmp++; if (bus.hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi: got %h want %h", bus.hi, 32'hFFFFFFFF); end
    n_cmp++; if (bus.lo !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mult_lo: got %h want %h", bus.lo, 32'hFFFFFFFE); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got %b want 0", bus.done); end
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 0, lat, bcnt);
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL multu_latency: got %0d want 34", lat); end
    n_cmp++; if (bus.hi !== 32'h00000001) begin n_err++; $display("FAIL multu_hi: got %h want %h", bus.hi, 32'h1); end
    n_cmp++; if (bus.lo !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_lo: got %h want %h", bus.lo, 32'hFFFFFFFE); end
  endtask

  task automatic test_div();
    @(negedge clk);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 0, lat, bcnt);
    n_cmp++; if (bus.lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo: got %h want %h", bus.lo, 32'hFFFFFFFD); end
    n_cmp++; if (bus.hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi: got %h want %h", bus.hi, 32'hFFFFFFFF); end
    @(negedge clk);
    run_op(OP_DIVU, 32'd100, 32'd7, 0, lat, bcnt);
    n_cmp++; if (bus.lo !== 32'd14) begin n_err++; $display("FAIL divu_lo: got %h want %h", bus.lo, 32'd14); end
    n_cmp++; if (bus.hi !== 32'd2) begin n_err++; $display("FAIL divu_hi: got %h want %h", bus.hi, 32'd2); end
  endtask

  task automatic test_div_edge();
    @(negedge clk);
    run_op(OP_DIVU, 32'h00000064, 32'h0, 0, lat, bcnt);
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL divz_latency: got %0d want 34", lat); end
    n_cmp++; if (bcnt !== 33) begin n_err++; $display("FAIL divz_busy_cycles: got %0d want 33", bcnt); end
    n_cmp++; if (bus.hi !== 32'h00000064) begin n_err++; $display("FAIL divz_hi: got %h want %h", bus.hi, 32'h64); end
    n_cmp++; if (bus.lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divz_lo: got %h want %h", bus.lo, 32'hFFFFFFFF); end
    @(negedge clk);
    run_op(OP_DIV, 32'hFFFFFFF0, 32'h0, 0, lat, bcnt);
    n_cmp++; if (bus.hi !== 32'hFFFFFFF0) begin n_err++; $display("FAIL divz_signed_hi: got %h want %h", bus.hi, 32'hFFFFFFF0); end
    n_cmp++; if (bus.lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divz_signed_lo: got %h want %h", bus.lo, 32'hFFFFFFFF); end
    @(negedge clk);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, lat, bcnt);
    n_cmp++; if (bus.lo !== 32'h80000000) begin n_err++; $display("FAIL div_ovf_lo: got %h want %h", bus.lo, 32'h80000000); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL div_ovf_hi: got %h want %h", bus.hi, 32'h0); end
  endtask

  task automatic test_reserved();
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'h0000AAAA; bus.b = 32'h1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rsvd_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL rsvd_hi: got %h want %h", bus.hi, 32'h0); end
    n_cmp++; if (bus.lo !== 32'h80000000) begin n_err++; $display("FAIL rsvd_lo: got %h want %h", bus.lo, 32'h80000000); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_op(OP_MULT, 32'd3, 32'd5, 10, lat, bcnt);
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL prot_latency: got %0d want 34", lat); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL prot_hi: got %h want %h", bus.hi, 32'h0); end
    n_cmp++; if (bus.lo !== 32'h0000000F) begin n_err++; $display("FAIL prot_lo: got %h want %h", bus.lo, 32'hF); end
    // Issued in the done cycle itself.
    run_op(OP_DIVU, 32'd1000, 32'd9, 0, lat, bcnt);
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL b2b_latency: got %0d want 34", lat); end
    n_cmp++; if (bus.lo !== 32'd111) begin n_err++; $display("FAIL b2b_lo: got %h want %h", bus.lo, 32'd111); end
    n_cmp++; if (bus.hi !== 32'd1) begin n_err++; $display("FAIL b2b_hi: got %h want %h", bus.hi, 32'd1); end
  endtask

  task automatic test_reset_mid_op();
    bit saw_done, saw_busy;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    bus.op = OP_MTLO; bus.a = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++; if (bus.hi !== 32'h11111111) begin n_err++; $display("FAIL preload_hi: got %h want %h", bus.hi, 32'h11111111); end
    n_cmp++; if (bus.lo !== 32'h22222222) begin n_err++; $display("FAIL preload_lo: got %h want %h", bus.lo, 32'h22222222); end
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd50; bus.b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (16) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL midop_busy: got %b want 1", bus.busy); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL arst_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL arst_hi: got %h want %h", bus.hi, 32'h0); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL arst_lo: got %h want %h", bus.lo, 32'h0); end
    @(negedge clk);
    rst = 1'b1;
    saw_done = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
      if (bus.busy === 1'b1) saw_busy = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL post_rst_done: got %b want 0", saw_done); end
    n_cmp++; if (saw_busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy: got %b want 0", saw_busy); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL post_rst_hi: got %h want %h", bus.hi, 32'h0); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL post_rst_lo: got %h want %h", bus.lo, 32'h0); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_mul();
    test_div();
    test_div_edge();
    test_reserved();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
